plic_claim_complete: RTL and testbench
======================================

// Module: plic_claim_complete
// PURPOSE
//  Multi-context PLIC claim/complete engine; each source has its own gateway (IDLE/PEND/INSVC).
//  Registers the claimed ID per context and clears that source's pending bit on claim.
//  Tracks which context owns each in-service source; re-arms the gateway on a valid complete.
//  Sits between the source gateways/arbiter (supplies best_id) and the per-context claim/complete register port.
// PARAMETERS
//  NSRC  31   number of interrupt sources; source IDs 1..NSRC, ID 0 = "no interrupt"
//  NCTX  2    number of target contexts (hart/privilege pairs)
//  IDW   5    ID width; must satisfy 2**IDW > NSRC
//  CW    1    owner-index width = max(1,$clog2(NCTX))
// PORTS
//  clk           in   1          clock
//  rstn          in   1          async active-low reset
//  irq_src       in   NSRC       level IRQ lines; bit i = source ID i+1
//  best_id       in   NCTX*IDW   per-context highest-priority pending ID from arbiter (0 = none)
//  claim_ena     in   NCTX       per-context claim-register read strobe, 1 cycle
//  complete_ena  in   NCTX       per-context claim-register write strobe, 1 cycle
//  complete_id   in   NCTX*IDW   per-context ID written on complete
//  claim_rdata   out  NCTX*IDW   registered claimed ID per context
//  pending       out  NSRC       pending bit per source (to arbiter)
//  in_service    out  NSRC       in-service bit per source
//  err_complete  out  NCTX       1-cycle pulse: complete from this context ignored
// BEHAVIOUR
//  Reset: all gateways IDLE; claim_rdata=0, pending=0, in_service=0, err_complete=0; owners=0.
//  Gateway per source s, 2-bit state:
//   IDLE  -> PEND  when irq_src[s-1]=1 (visible on pending one cycle later).
//   PEND  -> INSVC when s is granted to a claim; owner[s] <= claiming context.
//   INSVC -> IDLE  on a valid complete of s by owner[s].
//   Dropping irq_src while PEND does not clear pending; while INSVC, irq_src is ignored.
//   After INSVC->IDLE, a still-high irq_src re-pends on the next cycle (IDLE->PEND->...).
//  Claim (context c, claim_ena[c]=1):
//   Granted iff best_id[c] is in 1..NSRC and that source is PEND this cycle.
//   Granted: claim_rdata[c] <= best_id[c] at the next edge (1-cycle latency); else claim_rdata[c] <= 0.
//   Without claim_ena[c], claim_rdata[c] holds its value.
//   Same ID claimed by several contexts in one cycle: lowest-index context wins; the others read 0.
//  Complete (context c, complete_ena[c]=1, id=complete_id[c]):
//   Valid iff id is in 1..NSRC, the source is INSVC and owner[id]=c.
//   Otherwise no state change and err_complete[c]=1 for one cycle.
//   Multiple contexts may complete different IDs in the same cycle.
//  Simultaneous events:
//   Claim and complete in one cycle are independent (a source cannot be both PEND and INSVC).
//   Claim of X and complete of Y by the same context in one cycle: both take effect.
//  Purely synchronous apart from rstn. Reset mid-operation drops all in-service state; sources still high re-pend after reset.
//  No combinational path from any input to any output.
// TESTING
//  T1 reset: rstn low mid-INSVC -> all outputs 0; with irq_src[2] high, pending[2]=1 one cycle after release.
//  T2 basic flow: irq_src[4]=1 (ID5), best_id[0]=5, claim_ena[0] -> claim_rdata[0]=5 next cycle,
//     pending[4]=0, in_service[4]=1; complete_ena[0] with id 5 -> in_service[4]=0.
//  T3 race: both contexts claim ID3 in the same cycle -> claim_rdata ctx0=3, ctx1=0; owner=ctx0.
//  T4 bad complete: ctx1 completes ID3 owned by ctx0 -> err_complete[1]=1, in_service[2] stays 1.
//     Also complete ID0 and ID 31 with NSRC=30 -> err_complete pulses.
//  T5 level retrigger: keep irq_src[0] high through a complete of ID1 -> pending[0]=1 the cycle after
//     IDLE; pulse irq_src while PEND -> pending stays 1.
//  T6 empty claim: claim_ena with best_id=0 or a non-pending ID -> claim_rdata=0, no state change.

Source files
------------

// File: rtl/plic_claim_complete.sv
// PLIC claim/complete engine: one gateway per source (IDLE/PEND/INSVC), per-context
// claim registers, owner tracking for in-service sources, and completion checking.
module plic_claim_complete #(
    parameter int unsigned NSRC = 31,
    parameter int unsigned NCTX = 2,
    parameter int unsigned IDW  = 5,
    parameter int unsigned CW   = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NSRC-1:0]     irq_src,
    input  logic [NCTX*IDW-1:0] best_id,
    input  logic [NCTX-1:0]     claim_ena,
    input  logic [NCTX-1:0]     complete_ena,
    input  logic [NCTX*IDW-1:0] complete_id,
    output logic [NCTX*IDW-1:0] claim_rdata,
    output logic [NSRC-1:0]     pending,
    output logic [NSRC-1:0]     in_service,
    output logic [NCTX-1:0]     err_complete
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_INSVC = 2'd2;

    logic [1:0]     gw_q    [NSRC];
    logic [1:0]     gw_d    [NSRC];
    logic [CW-1:0]  owner_q [NSRC];
    logic [CW-1:0]  owner_d [NSRC];
    logic [IDW-1:0] rdata_q [NCTX];
    logic [IDW-1:0] rdata_d [NCTX];
    logic [NCTX-1:0] err_q, err_d;

    logic [IDW-1:0]  bid [NCTX];
    logic [IDW-1:0]  cid [NCTX];
    logic [NCTX-1:0] grant;
    logic [NCTX-1:0] cvalid;

    // Decide which claims are granted and which completes are valid this cycle.
    // IDs outside 1..NSRC never match a source, so the range check is implicit.
    always_comb begin
        logic hit;
        for (int c = 0; c < NCTX; c++) begin
            bid[c] = best_id[c*IDW +: IDW];
            cid[c] = complete_id[c*IDW +: IDW];
        end
        grant  = '0;
        cvalid = '0;
        for (int c = 0; c < NCTX; c++) begin
            hit = 1'b0;
            for (int s = 0; s < NSRC; s++) begin
                if (bid[c] == IDW'(s + 1) && gw_q[s] == ST_PEND) hit = 1'b1;
            end
            grant[c] = claim_ena[c] & hit;
            // Lowest-index context wins a contested ID.
            for (int k = 0; k < c; k++) begin
                if (grant[k] && bid[k] == bid[c]) grant[c] = 1'b0;
            end
            hit = 1'b0;
            for (int s = 0; s < NSRC; s++) begin
                if (cid[c] == IDW'(s + 1) && gw_q[s] == ST_INSVC && owner_q[s] == CW'(c)) begin
                    hit = 1'b1;
                end
            end
            cvalid[c] = complete_ena[c] & hit;
        end
    end

    // Gateway and owner next-state per source.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            gw_d[s]    = gw_q[s];
            owner_d[s] = owner_q[s];
            case (gw_q[s])
                ST_IDLE: begin
                    if (irq_src[s]) gw_d[s] = ST_PEND;
                end
                ST_PEND: begin
                    for (int c = 0; c < NCTX; c++) begin
                        if (grant[c] && bid[c] == IDW'(s + 1)) begin
                            gw_d[s]    = ST_INSVC;
                            owner_d[s] = CW'(c);
                        end
                    end
                end
                ST_INSVC: begin
                    for (int c = 0; c < NCTX; c++) begin
                        if (cvalid[c] && cid[c] == IDW'(s + 1)) gw_d[s] = ST_IDLE;
                    end
                end
                default: gw_d[s] = ST_IDLE;
            endcase
        end
    end

    // Claim read data and completion error next-state per context.
    always_comb begin
        for (int c = 0; c < NCTX; c++) begin
            rdata_d[c] = rdata_q[c];
            if (claim_ena[c]) rdata_d[c] = grant[c] ? bid[c] : '0;
            err_d[c] = complete_ena[c] & ~cvalid[c];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < NSRC; s++) begin
                gw_q[s]    <= ST_IDLE;
                owner_q[s] <= '0;
            end
            for (int c = 0; c < NCTX; c++) rdata_q[c] <= '0;
            err_q <= '0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                gw_q[s]    <= gw_d[s];
                owner_q[s] <= owner_d[s];
            end
            for (int c = 0; c < NCTX; c++) rdata_q[c] <= rdata_d[c];
            err_q <= err_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            pending[s]    = (gw_q[s] == ST_PEND);
            in_service[s] = (gw_q[s] == ST_INSVC);
        end
        for (int c = 0; c < NCTX; c++) claim_rdata[c*IDW +: IDW] = rdata_q[c];
        err_complete = err_q;
    end

endmodule

// File: tb/tb_plic_claim_complete.sv
// Directed bench for plic_claim_complete with NSRC=30 so that ID 31 is out of range.
module tb_plic_claim_complete;

    localparam int unsigned NSRC = 30;
    localparam int unsigned NCTX = 2;
    localparam int unsigned IDW  = 5;
    localparam int unsigned CW   = 1;

    logic            clk;
    logic            rstn;
    logic [NSRC-1:0] irq_src;
    logic [IDW-1:0]  best0, best1, cid0, cid1;
    logic [1:0]      claim_ena, complete_ena;
    logic [2*IDW-1:0] claim_rdata;
    logic [NSRC-1:0] pending, in_service;
    logic [1:0]      err_complete;
    logic [IDW-1:0]  rd0, rd1;

    int checks = 0;
    int errors = 0;

    assign rd0 = claim_rdata[IDW-1:0];
    assign rd1 = claim_rdata[2*IDW-1:IDW];

    plic_claim_complete #(.NSRC(NSRC), .NCTX(NCTX), .IDW(IDW), .CW(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .irq_src      (irq_src),
        .best_id      ({best1, best0}),
        .claim_ena    (claim_ena),
        .complete_ena (complete_ena),
        .complete_id  ({cid1, cid0}),
        .claim_rdata  (claim_rdata),
        .pending      (pending),
        .in_service   (in_service),
        .err_complete (err_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs set after this take effect at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        claim_ena    = 2'b00;
        complete_ena = 2'b00;
        best0 = '0; best1 = '0; cid0 = '0; cid1 = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        irq_src = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pending !== '0 || in_service !== '0 || claim_rdata !== '0 || err_complete !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pending=%h insvc=%h rdata=%h err=%b, want all 0",
                     pending, in_service, claim_rdata, err_complete);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        irq_src[4] = 1'b1;
        tick();
        checks++;
        if (pending[4] !== 1'b1) begin
            errors++; $display("FAIL basic_pend: got %b want 1", pending[4]);
        end
        claim_ena = 2'b01; best0 = 5'd5;
        tick();
        checks++;
        if (rd0 !== 5'd5 || pending[4] !== 1'b0 || in_service[4] !== 1'b1) begin
            errors++;
            $display("FAIL basic_claim: rdata0=%0d pend=%b insvc=%b want 5/0/1",
                     rd0, pending[4], in_service[4]);
        end
        idle_inputs(); irq_src[4] = 1'b0;
        tick();
        checks++;
        if (rd0 !== 5'd5 || in_service[4] !== 1'b1) begin
            errors++; $display("FAIL basic_hold: rdata0=%0d insvc=%b want 5/1", rd0, in_service[4]);
        end
        complete_ena = 2'b01; cid0 = 5'd5;
        tick();
        checks++;
        if (in_service[4] !== 1'b0 || pending[4] !== 1'b0 || err_complete !== 2'b00) begin
            errors++;
            $display("FAIL basic_complete: insvc=%b pend=%b err=%b want 0/0/00",
                     in_service[4], pending[4], err_complete);
        end
        idle_inputs();
    endtask

    task automatic test_race();
        irq_src[2] = 1'b1;
        tick();
        claim_ena = 2'b11; best0 = 5'd3; best1 = 5'd3;
        tick();
        checks++;
        if (rd0 !== 5'd3 || rd1 !== 5'd0 || in_service[2] !== 1'b1) begin
            errors++;
            $display("FAIL race: rdata0=%0d rdata1=%0d insvc=%b want 3/0/1", rd0, rd1, in_service[2]);
        end
        idle_inputs(); irq_src[2] = 1'b0;
    endtask

    task automatic test_bad_complete();
        complete_ena = 2'b10; cid1 = 5'd3;
        tick();
        checks++;
        if (err_complete !== 2'b10 || in_service[2] !== 1'b1) begin
            errors++;
            $display("FAIL bad_owner: err=%b insvc=%b want 10/1", err_complete, in_service[2]);
        end
        idle_inputs();
        tick();
        checks++;
        if (err_complete !== 2'b00) begin
            errors++; $display("FAIL err_pulse: err=%b want 00", err_complete);
        end
        complete_ena = 2'b11; cid0 = 5'd0; cid1 = 5'd31;
        tick();
        checks++;
        if (err_complete !== 2'b11 || in_service[2] !== 1'b1) begin
            errors++;
            $display("FAIL bad_range: err=%b insvc=%b want 11/1", err_complete, in_service[2]);
        end
        idle_inputs();
        complete_ena = 2'b01; cid0 = 5'd3;
        tick();
        checks++;
        if (err_complete !== 2'b00 || in_service[2] !== 1'b0) begin
            errors++;
            $display("FAIL owner_complete: err=%b insvc=%b want 00/0", err_complete, in_service[2]);
        end
        idle_inputs();
    endtask

    task automatic test_retrigger();
        irq_src[0] = 1'b1;
        tick();
        claim_ena = 2'b10; best1 = 5'd1;
        tick();
        checks++;
        if (rd1 !== 5'd1 || in_service[0] !== 1'b1) begin
            errors++; $display("FAIL retrig_claim: rdata1=%0d insvc=%b want 1/1", rd1, in_service[0]);
        end
        idle_inputs();
        complete_ena = 2'b10; cid1 = 5'd1;
        tick();
        checks++;
        if (in_service[0] !== 1'b0 || pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL retrig_idle: insvc=%b pend=%b want 0/0", in_service[0], pending[0]);
        end
        idle_inputs();
        tick();
        checks++;
        if (pending[0] !== 1'b1) begin
            errors++; $display("FAIL retrig_repend: pend=%b want 1", pending[0]);
        end
        irq_src[0] = 1'b0;
        tick();
        irq_src[0] = 1'b1;
        tick();
        checks++;
        if (pending[0] !== 1'b1) begin
            errors++; $display("FAIL retrig_sticky: pend=%b want 1", pending[0]);
        end
        irq_src[0] = 1'b0;
        claim_ena = 2'b01; best0 = 5'd1;
        tick();
        idle_inputs();
        complete_ena = 2'b01; cid0 = 5'd1;
        tick();
        checks++;
        if (in_service[0] !== 1'b0 || pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL retrig_clean: insvc=%b pend=%b want 0/0", in_service[0], pending[0]);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        irq_src[5] = 1'b1; irq_src[6] = 1'b1;
        tick();
        irq_src[5] = 1'b0; irq_src[6] = 1'b0;
        claim_ena = 2'b01; best0 = 5'd6;
        tick();
        claim_ena = 2'b01; best0 = 5'd7; complete_ena = 2'b01; cid0 = 5'd6;
        tick();
        checks++;
        if (rd0 !== 5'd7 || in_service[5] !== 1'b0 || in_service[6] !== 1'b1 ||
            err_complete !== 2'b00) begin
            errors++;
            $display("FAIL b2b: rdata0=%0d insvc6=%b insvc7=%b err=%b want 7/0/1/00",
                     rd0, in_service[5], in_service[6], err_complete);
        end
        idle_inputs();
        complete_ena = 2'b01; cid0 = 5'd7;
        tick();
        idle_inputs();
    endtask

    task automatic test_empty_claim();
        irq_src[9] = 1'b1;
        tick();
        irq_src[9] = 1'b0;
        claim_ena = 2'b01; best0 = 5'd0;
        tick();
        checks++;
        if (rd0 !== 5'd0) begin
            errors++; $display("FAIL empty_zero: rdata0=%0d want 0", rd0);
        end
        claim_ena = 2'b11; best0 = 5'd4; best1 = 5'd31;
        tick();
        checks++;
        if (rd0 !== 5'd0 || rd1 !== 5'd0 || pending[9] !== 1'b1 || in_service !== '0) begin
            errors++;
            $display("FAIL empty_nopend: rdata0=%0d rdata1=%0d pend10=%b insvc=%h want 0/0/1/0",
                     rd0, rd1, pending[9], in_service);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        irq_src[1] = 1'b1;
        tick();
        irq_src[1] = 1'b0;
        claim_ena = 2'b10; best1 = 5'd2;
        tick();
        idle_inputs();
        irq_src[2] = 1'b1;
        checks++;
        if (in_service[1] !== 1'b1 || rd1 !== 5'd2) begin
            errors++; $display("FAIL mid_setup: insvc=%b rdata1=%0d want 1/2", in_service[1], rd1);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (pending !== '0 || in_service !== '0 || claim_rdata !== '0 || err_complete !== '0) begin
            errors++;
            $display("FAIL mid_reset: pending=%h insvc=%h rdata=%h err=%b want all 0",
                     pending, in_service, claim_rdata, err_complete);
        end
        tick();
        rstn = 1'b1;
        checks++;
        if (pending[2] !== 1'b0) begin
            errors++; $display("FAIL mid_release: pend3=%b want 0", pending[2]);
        end
        tick();
        checks++;
        if (pending[2] !== 1'b1 || in_service !== '0) begin
            errors++;
            $display("FAIL mid_repend: pend3=%b insvc=%h want 1/0", pending[2], in_service);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_race();
        test_bad_complete();
        test_retrigger();
        test_back_to_back();
        test_empty_claim();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
